// File: rtl/ntt_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg : shared Kyber NTT constants, address types and sequencer states - rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ntt_pkg;

  localparam int KYBER_N    = 256;
  localparam int KYBER_Q    = 3329;
  localparam int LOG_N      = 8;
  localparam int NTT_LAYERS = 7;

  typedef logic [7:0] coef_addr_t;
  typedef logic [6:0] zeta_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } ntt_sched_state_t;

  // One entry of the write-back delay line.
  typedef struct packed {
    logic       valid;
    coef_addr_t addr_a;
    coef_addr_t addr_b;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/ntt_addr_gen.sv
// ---------------------------------------------------------------------------
// ntt_addr_gen : (layer, butterfly, inv) -> coefficient addresses and zeta index - rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic [2:0] layer,
  input  logic [6:0] bf,
  input  logic       inv,
  output coef_addr_t addr_a,
  output coef_addr_t addr_b,
  output zeta_idx_t  zeta_idx
);

  logic [3:0] s;
  logic [7:0] len;
  logic [7:0] b8;
  logic [7:0] grp;
  logic [7:0] zsum;

  always_comb begin
    b8 = {1'b0, bf};
    if (inv) begin
      s   = {1'b0, layer} + 4'd1;
      len = 8'd2 << layer;
    end else begin
      s   = 4'd7 - {1'b0, layer};
      len = 8'd128 >> layer;
    end
    grp    = b8 >> s;
    addr_a = (grp << (s + 4'd1)) | (b8 & (len - 8'd1));
    addr_b = addr_a + len;
    // Forward walks zetas upward per layer, inverse walks them back down.
    if (inv) zsum = (8'd128 >> layer) - 8'd1 - grp;
    else     zsum = (8'd1 << layer) + grp;
    zeta_idx = zsum[6:0];
  end

endmodule

`default_nettype wire

// File: rtl/ntt_sched.sv
// ---------------------------------------------------------------------------
// ntt_sched : 1-butterfly/cycle Kyber NTT sequencer; NTT_SCHED_INV_EN adds inverse - rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ntt_sched
  import ntt_pkg::*;
#(
  parameter int N      = 256,
  parameter int BF_LAT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef NTT_SCHED_INV_EN
  input  logic       inv,
  output logic       bf_mode,
`endif
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output coef_addr_t rd_addr_a,
  output coef_addr_t rd_addr_b,
  output zeta_idx_t  zeta_idx,
  output logic       wr_en,
  output coef_addr_t wr_addr_a,
  output coef_addr_t wr_addr_b,
  output logic [2:0] layer
);

  generate
    if (N != KYBER_N) begin : g_bad_n
      $error("ntt_sched: N must be 256");
    end
    if (BF_LAT < 1 || BF_LAT > 8) begin : g_bad_lat
      $error("ntt_sched: BF_LAT must be 1..8");
    end
  endgenerate

  localparam logic [3:0] DRAIN_LAST = 4'(BF_LAT - 1);
  localparam logic [2:0] LAST_LAYER = 3'(NTT_LAYERS - 1);

  ntt_sched_state_t state;
  logic [7:0]       b_cnt;
  logic [3:0]       drain_cnt;
  logic [2:0]       gen_layer;
  logic [6:0]       gen_b;
  logic             gen_inv;
  coef_addr_t       gen_a;
  coef_addr_t       gen_b_addr;
  zeta_idx_t        gen_zeta;
  wb_entry_t        pipe [BF_LAT];

`ifdef NTT_SCHED_INV_EN
  logic inv_q;
  assign bf_mode = inv_q;
  assign gen_inv = (state == IDLE) ? inv : inv_q;
`else
  assign gen_inv = 1'b0;
`endif

  // The generator is fed the butterfly to be issued at the coming edge, so in
  // DRAIN it already looks at butterfly 0 of the next layer.
  always_comb begin
    gen_layer = layer;
    gen_b     = b_cnt[6:0];
    if (state == DRAIN) begin
      gen_layer = layer + 3'd1;
      gen_b     = '0;
    end
  end

  ntt_addr_gen u_addr_gen (
    .layer   (gen_layer),
    .bf      (gen_b),
    .inv     (gen_inv),
    .addr_a  (gen_a),
    .addr_b  (gen_b_addr),
    .zeta_idx(gen_zeta)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      zeta_idx  <= '0;
      layer     <= '0;
      b_cnt     <= '0;
      drain_cnt <= '0;
`ifdef NTT_SCHED_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr_a <= gen_a;
            rd_addr_b <= gen_b_addr;
            zeta_idx  <= gen_zeta;
            b_cnt     <= 8'd1;
`ifdef NTT_SCHED_INV_EN
            inv_q     <= inv;
`endif
          end
        end
        ISSUE: begin
          if (b_cnt[7]) begin
            state     <= DRAIN;
            rd_en     <= 1'b0;
            drain_cnt <= '0;
          end else begin
            rd_en     <= 1'b1;
            rd_addr_a <= gen_a;
            rd_addr_b <= gen_b_addr;
            zeta_idx  <= gen_zeta;
            b_cnt     <= b_cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            if (layer != LAST_LAYER) begin
              state     <= ISSUE;
              layer     <= layer + 3'd1;
              rd_en     <= 1'b1;
              rd_addr_a <= gen_a;
              rd_addr_b <= gen_b_addr;
              zeta_idx  <= gen_zeta;
              b_cnt     <= 8'd1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              layer <= '0;
              b_cnt <= '0;
            end
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back delay line; a reset flushes every pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BF_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int i = 1; i < BF_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign wr_en     = pipe[BF_LAT-1].valid;
  assign wr_addr_a = pipe[BF_LAT-1].addr_a;
  assign wr_addr_b = pipe[BF_LAT-1].addr_b;

endmodule

`default_nettype wire

// File: tb/tb_ntt_sched.sv
// ---------------------------------------------------------------------------
// tb_ntt_sched : directed self-checking bench for ntt_sched (NTT_SCHED_INV_EN optional) - rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ntt_sched;

  localparam int BF_LAT = 3;
  localparam int Q      = 3329;
  localparam int PERIOD = 7 * (128 + BF_LAT) + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, rd_en, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] zeta_idx;
  logic [2:0] layer;
`ifdef NTT_SCHED_INV_EN
  logic       inv = 1'b0;
  logic       bf_mode;
  logic       exp_mode = 1'b0;
  int         mode_err;
`endif

  ntt_sched #(.N(256), .BF_LAT(BF_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef NTT_SCHED_INV_EN
    .inv      (inv),
    .bf_mode  (bf_mode),
`endif
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .zeta_idx (zeta_idx),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b),
    .layer    (layer)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int bitrev7(input int v);
    int r = 0;
    for (int i = 0; i < 7; i++) if (v[i]) r |= (1 << (6 - i));
    return r;
  endfunction

  function automatic int powmod(input int base, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * base) % Q;
    return r;
  endfunction

  int zetas [128];
  int ref_ram [256];

  // Reference RAM driven by the DUT schedule, plus scoreboard of issued butterflies.
  typedef struct {
    int a; int b; int na; int nb; int rc;
  } pend_t;
  pend_t pend [$];
  int    ram [256];
  int    done_q [$];
  logic  mon_clr = 1'b0;
  int    rd_cnt, wr_cnt, done_cnt, sb_err, busy_err, first_rd;
  int    fa, fb, fz, l6a, l6b, l6z, la, lb, lz;

  always @(negedge clk) begin
    pend_t e;
    int    av, t;
    if (mon_clr) begin
      rd_cnt = 0; wr_cnt = 0; done_cnt = 0; sb_err = 0; busy_err = 0; first_rd = -1;
      fa = -1; fb = -1; fz = -1; l6a = -1; l6b = -1; l6z = -1; la = -1; lb = -1; lz = -1;
      pend.delete();
      done_q.delete();
      for (int i = 0; i < 256; i++) ram[i] = i;
`ifdef NTT_SCHED_INV_EN
      mode_err = 0;
`endif
    end else begin
      if (done) begin
        done_cnt++;
        done_q.push_back(cyc);
        if (busy) busy_err++;
      end
      if (rd_en) begin
        if (!busy) busy_err++;
        if (rd_cnt == 0) begin
          first_rd = cyc; fa = rd_addr_a; fb = rd_addr_b; fz = zeta_idx;
        end
        if (rd_cnt == 6 * 128 + 5) begin
          l6a = rd_addr_a; l6b = rd_addr_b; l6z = zeta_idx;
        end
        la = rd_addr_a; lb = rd_addr_b; lz = zeta_idx;
        av   = ram[rd_addr_a];
        t    = (zetas[zeta_idx] * ram[rd_addr_b]) % Q;
        e.a  = rd_addr_a;
        e.b  = rd_addr_b;
        e.na = (av + t) % Q;
        e.nb = (av - t + Q) % Q;
        e.rc = cyc;
        pend.push_back(e);
        rd_cnt++;
      end
      if (wr_en) begin
        wr_cnt++;
        if (pend.size() == 0) sb_err++;
        else begin
          e = pend.pop_front();
          if (e.a != int'(wr_addr_a) || e.b != int'(wr_addr_b) || cyc - e.rc != BF_LAT) sb_err++;
          ram[wr_addr_a] = e.na;
          ram[wr_addr_b] = e.nb;
        end
      end
`ifdef NTT_SCHED_INV_EN
      if (busy && bf_mode !== exp_mode) mode_err++;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start(output int t0);
    tick();
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) tick();
  endtask

  function automatic int first_done();
    return (done_q.size() > 0) ? done_q[0] : -1;
  endfunction

  initial begin
    int t0, mism, range_err, k, z, t;

    for (int i = 0; i < 128; i++) zetas[i] = powmod(17, bitrev7(i));
    for (int i = 0; i < 256; i++) ref_ram[i] = i;
    k = 1;
    for (int len = 128; len >= 2; len = len / 2) begin
      for (int st = 0; st < 256; st = st + 2 * len) begin
        z = zetas[k];
        k++;
        for (int j = st; j < st + len; j++) begin
          t = (z * ref_ram[j + len]) % Q;
          ref_ram[j + len] = (ref_ram[j] - t + Q) % Q;
          ref_ram[j]       = (ref_ram[j] + t) % Q;
        end
      end
    end

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_strobes", {done, rd_en, wr_en}, 0);
    check("rst_addrs", {rd_addr_a, rd_addr_b, zeta_idx, wr_addr_a, wr_addr_b, layer}, 0);
    reset = 1'b0;
    clear_mon();

    // Forward transform with reference RAM and scoreboard
    pulse_start(t0);
    wait_done(2 * PERIOD);
    repeat (2) tick();
    check("fwd_first_rd_cyc", first_rd, t0 + 1);
    check("fwd_first_a", fa, 0);
    check("fwd_first_b", fb, 128);
    check("fwd_first_zeta", fz, 1);
    check("fwd_done_cyc", first_done(), t0 + PERIOD);
    check("fwd_done_cnt", done_cnt, 1);
    check("fwd_rd_cnt", rd_cnt, 896);
    check("fwd_wr_cnt", wr_cnt, 896);
    check("fwd_scoreboard_err", sb_err, 0);
    check("fwd_busy_err", busy_err, 0);
    check("l6_b5_a", l6a, 9);
    check("l6_b5_b", l6b, 11);
    check("l6_b5_zeta", l6z, 66);
    mism = 0;
    range_err = 0;
    for (int i = 0; i < 256; i++) begin
      if (ram[i] != ref_ram[i]) mism++;
      if (ram[i] < 0 || ram[i] >= Q) range_err++;
    end
    check("ntt_ram_mismatches", mism, 0);
    check("ntt_ram_range_err", range_err, 0);

    // Start held high: back-to-back transforms, second accepted in the done cycle
    clear_mon();
    tick();
    start = 1'b1;
    t0 = cyc;
    repeat (2000) tick();
    start = 1'b0;
    check("held_done_count", done_q.size(), 2);
    check("held_done0_cyc", first_done(), t0 + PERIOD);
    check("held_done1_cyc", (done_q.size() > 1) ? done_q[1] : -1, t0 + 2 * PERIOD);
    check("held_busy_err", busy_err, 0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    clear_mon();

    // Reset mid-transform flushes pending writes
    pulse_start(t0);
    while (cyc < t0 + 400) tick();
    reset = 1'b1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_wr_en", wr_en, 0);
    reset = 1'b0;
    clear_mon();
    repeat (20) tick();
    check("midrst_late_wr_rd", wr_cnt + rd_cnt, 0);
    pulse_start(t0);
    wait_done(2 * PERIOD);
    repeat (2) tick();
    check("midrst_restart_done", first_done(), t0 + PERIOD);
    check("midrst_restart_wr", wr_cnt, 896);

`ifdef NTT_SCHED_INV_EN
    // Inverse schedule
    clear_mon();
    exp_mode = 1'b1;
    inv = 1'b1;
    pulse_start(t0);
    inv = 1'b0;
    wait_done(2 * PERIOD);
    repeat (2) tick();
    check("inv_first_a", fa, 0);
    check("inv_first_b", fb, 2);
    check("inv_first_zeta", fz, 127);
    check("inv_last_a", la, 127);
    check("inv_last_b", lb, 255);
    check("inv_last_zeta", lz, 1);
    check("inv_mode_err", mode_err, 0);
    check("inv_done_cyc", first_done(), t0 + PERIOD);
    check("inv_rd_cnt", rd_cnt, 896);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
